// File: rtl/demux32_12_buf.sv
// 1-to-2 demultiplexer for 32-bit words with an independent FIFO per output channel,
// so a stalled consumer on one channel never blocks traffic routed to the other.
module demux32_12_buf #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] in_data,
    input  logic        in_sel,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] o0_data,
    output logic        o0_valid,
    input  logic        o0_ready,
    output logic [31:0] o1_data,
    output logic        o1_valid,
    input  logic        o1_ready,
    output logic [7:0]  cnt0,
    output logic [7:0]  cnt1
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [31:0]   mem_r    [2][DEPTH];
    logic [AW-1:0] wr_ptr_r [2];
    logic [AW-1:0] rd_ptr_r [2];
    logic [AW:0]   count_r  [2];
    logic [7:0]    cnt_r    [2];

    logic [1:0] full_s;
    logic [1:0] valid_s;
    logic [1:0] push_s;
    logic [1:0] pop_s;
    logic       in_ready_s;

    // Per-channel status, input handshake and push/pop strobes
    always_comb begin
        full_s  = 2'b00;
        valid_s = 2'b00;
        for (int k = 0; k < 2; k++) begin
            full_s[k]  = (count_r[k] == FULL_CNT);
            valid_s[k] = (count_r[k] != {(AW+1){1'b0}});
        end
        // A full channel still accepts when its head leaves on the same edge
        if (in_sel) begin
            in_ready_s = !full_s[1] || o1_ready;
        end else begin
            in_ready_s = !full_s[0] || o0_ready;
        end
        if (in_valid && in_ready_s) begin
            push_s = in_sel ? 2'b10 : 2'b01;
        end else begin
            push_s = 2'b00;
        end
        pop_s = valid_s & {o1_ready, o0_ready};
    end

    // Storage array; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (push_s[k]) begin
                mem_r[k][wr_ptr_r[k]] <= in_data;
            end
        end
    end

    // Pointers, occupancy and acceptance counters per channel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                wr_ptr_r[k] <= {AW{1'b0}};
                rd_ptr_r[k] <= {AW{1'b0}};
                count_r[k]  <= {(AW+1){1'b0}};
                cnt_r[k]    <= 8'd0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (push_s[k]) begin
                    wr_ptr_r[k] <= wr_ptr_r[k] + AW'(1);
                    cnt_r[k]    <= cnt_r[k] + 8'd1;
                end
                if (pop_s[k]) begin
                    rd_ptr_r[k] <= rd_ptr_r[k] + AW'(1);
                end
                case ({push_s[k], pop_s[k]})
                    2'b10:   count_r[k] <= count_r[k] + (AW+1)'(1);
                    2'b01:   count_r[k] <= count_r[k] - (AW+1)'(1);
                    default: count_r[k] <= count_r[k];
                endcase
            end
        end
    end

    assign in_ready = in_ready_s;
    assign o0_valid = valid_s[0];
    assign o1_valid = valid_s[1];
    // Head word is masked to zero while the channel is empty
    assign o0_data  = valid_s[0] ? mem_r[0][rd_ptr_r[0]] : 32'h0000_0000;
    assign o1_data  = valid_s[1] ? mem_r[1][rd_ptr_r[1]] : 32'h0000_0000;
    assign cnt0     = cnt_r[0];
    assign cnt1     = cnt_r[1];

endmodule
